toe_rx_dma: RTL



---
 rtl/toe_rx_dma.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/toe_rx_dma.sv
// ---------------------------------------------------------------------------
// toe_rx_dma -- receive-side DMA engine of the TCP offload engine.
//
// Takes packet words from the parser on a valid/ready stream and writes them
// into a software-managed ring in shared SRAM. Each packet is stored as one
// header word followed by its payload. The header is {trunc, 15'b0, len[15:0]}
// and len counts only the payload bytes actually written. Firmware frees
// space by advancing rd_ptr_i. At most one memory write is in flight.
//
// Optional feature macro: TOE_RX_DMA_STATS_EN adds the pkt_cnt_o and
// drop_cnt_o counters.
//
// Ports (PW = clog2(BufWords)+1, pointers carry a wrap bit):
//   clk_i, rst_i        clock and synchronous active-high reset
//   cfg_en_i            enable acceptance of new packets
//   cfg_base_i          ring base byte address, word aligned
//   rd_ptr_i            consumer word pointer
//   wr_ptr_o            producer word pointer, advanced on packet commit
//   irq_o               one-cycle pulse per committed packet
//   s_valid_i/s_ready_o stream handshake
//   s_data_i/s_be_i     stream data and byte enables
//   s_last_i            last beat of packet
//   mem_req_o/mem_we_o  memory request, always a write
//   mem_gnt_i           request granted
//   mem_addr_o          byte address
//   mem_be_o            byte enables
//   mem_wdata_o         write data
//   mem_rvalid_i        write completion
//   pkt_cnt_o           committed packets (stats build only)
//   drop_cnt_o          dropped packets (stats build only)
// ---------------------------------------------------------------------------
module toe_rx_dma #(
    parameter int  AddrWidth   = 32,
    parameter int  DataWidth   = 32,
    parameter int  BufWords    = 1024,
    parameter int  MaxPktWords = 512,
    localparam int PW          = $clog2(BufWords) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [PW-1:0]        rd_ptr_i,
    output logic [PW-1:0]        wr_ptr_o,
    output logic                 irq_o,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DataWidth-1:0] s_data_i,
    input  logic [3:0]           s_be_i,
    input  logic                 s_last_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_rvalid_i
`ifdef TOE_RX_DMA_STATS_EN
    ,
    output logic [31:0]          pkt_cnt_o,
    output logic [31:0]          drop_cnt_o
`endif
);

    localparam int IW = $clog2(BufWords);        // ring index bits
    localparam int CW = $clog2(MaxPktWords + 1); // written-word counter bits

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_HEADER,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_hdr_idx;
    logic [PW-1:0]        r_nxt_idx;
    logic [CW-1:0]        r_words;
    logic [15:0]          r_len;
    logic                 r_trunc;
    logic                 r_req;
    logic                 r_outstanding;
    logic                 r_hdr_sent;
    logic                 r_irq;
    logic [AddrWidth-1:0] r_addr;
    logic [3:0]           r_be;
    logic [DataWidth-1:0] r_wdata;

    logic                 w_busy;
    logic                 w_mem_free;
    logic [PW-1:0]        w_used;
    logic [PW:0]          w_free;
    logic                 w_space_ok;
    logic                 w_room;
    logic                 w_ready;
    logic                 w_fire;
    logic                 w_start;
    logic                 w_write;
    logic                 w_trunc_beat;
    logic                 w_issue_hdr;
    logic                 w_commit;
    logic                 w_drop_evt;
    logic [PW-1:0]        w_wr_idx;
    logic [CW-1:0]        w_words_base;
    logic [15:0]          w_len_base;

    function automatic logic [AddrWidth-1:0] idx_addr(input logic [AddrWidth-1:0] base,
                                                      input logic [PW-1:0]        idx);
        // Only the low IW bits select the slot; the top bit is the wrap flag.
        return base + AddrWidth'({idx[IW-1:0], 2'b00});
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] be);
        return 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
    endfunction

    // A write is pending from request until its completion arrives.
    assign w_busy = r_req | r_outstanding;
    // True when the memory port can take a new request at the next edge,
    // including the cycle in which the previous write completes.
    assign w_mem_free = ~r_req & (~r_outstanding | mem_rvalid_i);

    assign w_used     = r_wr_ptr - rd_ptr_i;
    assign w_free     = (PW + 1)'(BufWords) - {1'b0, w_used};
    assign w_space_ok = (w_free >= (PW + 1)'(MaxPktWords + 1));
    assign w_room     = (r_words < CW'(MaxPktWords));

    // Beats are never accepted while reset is asserted.
    assign s_ready_o = w_ready & ~rst_i;
    assign w_fire    = s_valid_i & s_ready_o;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its sources.
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_start      = 1'b0;
        w_write      = 1'b0;
        w_trunc_beat = 1'b0;
        w_issue_hdr  = 1'b0;
        w_commit     = 1'b0;
        w_drop_evt   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_ready = cfg_en_i & ~w_busy;
                if (w_fire) begin
                    if (w_space_ok) begin
                        w_start     = 1'b1;
                        w_write     = 1'b1;
                        w_state_nxt = s_last_i ? S_HEADER : S_PAYLOAD;
                    end else begin
                        // Not enough room for a worst-case packet: discard it
                        // without touching memory.
                        w_drop_evt  = 1'b1;
                        w_state_nxt = s_last_i ? S_IDLE : S_DROP;
                    end
                end
            end

            S_PAYLOAD: begin
                w_ready = ~w_busy;
                if (w_fire) begin
                    w_write      = w_room;
                    w_trunc_beat = ~w_room;
                    if (s_last_i) begin
                        w_state_nxt = S_HEADER;
                    end
                end
            end

            S_HEADER: begin
                if (!r_hdr_sent && w_mem_free) begin
                    w_issue_hdr = 1'b1;
                end
                if (r_hdr_sent && r_outstanding && mem_rvalid_i) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_DROP: begin
                w_ready = 1'b1;
                if (w_fire && s_last_i) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Payload slot and running totals restart at the first beat of a packet.
    assign w_wr_idx     = w_start ? (r_wr_ptr + PW'(1)) : r_nxt_idx;
    assign w_words_base = w_start ? '0 : r_words;
    assign w_len_base   = w_start ? '0 : r_len;

    // -----------------------------------------------------------------------
    // Datapath: memory request, packet bookkeeping, producer pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_hdr_idx     <= '0;
            r_nxt_idx     <= '0;
            r_words       <= '0;
            r_len         <= '0;
            r_trunc       <= 1'b0;
            r_req         <= 1'b0;
            r_outstanding <= 1'b0;
            r_hdr_sent    <= 1'b0;
            r_irq         <= 1'b0;
            r_addr        <= '0;
            r_be          <= '0;
            r_wdata       <= '0;
        end else begin
            r_irq <= 1'b0;

            // Completion is only honoured for a write we actually launched,
            // so a stale response after reset is ignored.
            if (r_outstanding && mem_rvalid_i) begin
                r_outstanding <= 1'b0;
            end
            if (r_req && mem_gnt_i) begin
                r_req         <= 1'b0;
                r_outstanding <= 1'b1;
            end

            if (w_start) begin
                r_hdr_idx  <= r_wr_ptr;
                r_trunc    <= 1'b0;
                r_hdr_sent <= 1'b0;
            end

            if (w_write) begin
                r_req     <= 1'b1;
                r_addr    <= idx_addr(cfg_base_i, w_wr_idx);
                r_be      <= s_be_i;
                r_wdata   <= s_data_i;
                r_nxt_idx <= w_wr_idx + PW'(1);
                r_words   <= w_words_base + CW'(1);
                r_len     <= w_len_base + 16'(popcount4(s_be_i));
            end

            if (w_trunc_beat) begin
                r_trunc <= 1'b1;
            end

            if (w_issue_hdr) begin
                r_req      <= 1'b1;
                r_addr     <= idx_addr(cfg_base_i, r_hdr_idx);
                r_be       <= 4'hF;
                r_wdata    <= DataWidth'({r_trunc, 15'b0, r_len});
                r_hdr_sent <= 1'b1;
            end

            if (w_commit) begin
                r_wr_ptr   <= r_hdr_idx + PW'(1) + PW'(r_words);
                r_irq      <= 1'b1;
                r_hdr_sent <= 1'b0;
            end
        end
    end

    assign wr_ptr_o    = r_wr_ptr;
    assign irq_o       = r_irq;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_req;
    assign mem_addr_o  = r_addr;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;

`ifdef TOE_RX_DMA_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_drop_cnt;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_commit) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_drop_evt) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign pkt_cnt_o  = r_pkt_cnt;
    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule
